// File: rtl/ps2_key_rx_if.sv
// PS/2 receiver bus: raw connector lines in, byte history and strobes out.
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] key;
  logic        ready;
  logic        err;

  modport master (output ps2_clk, ps2_data, input key, ready, err);
  modport slave  (input ps2_clk, ps2_data, output key, ready, err);
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host frame receiver with glitch filter, mid-frame timeout and byte history.
// Define PS2_PARITY_CHECK_EN to reject frames with bad parity/stop (err strobe); otherwise err is 0.
module ps2_key_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  ps2_key_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          filt_clk;
  logic [FW-1:0] flt_cnt;
  logic          flt_hit, bit_evt;
  logic [TW-1:0] tcnt;
  logic          to_hit;
  state_t        state, state_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shift, shift_d;
  logic          done, frame_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
    end
  end
  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample; the
  // bit event fires in that same cycle so the FSM sees data aligned with it.
  assign flt_hit = (clk_s != filt_clk) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign bit_evt = flt_hit && filt_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s == filt_clk) begin
      flt_cnt  <= '0;
    end else if (flt_hit) begin
      filt_clk <= clk_s;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  assign to_hit = (state != IDLE) && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         tcnt <= '0;
    else if (bit_evt || state == IDLE) tcnt <= '0;
    else                             tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    done      = 1'b0;
    if (bit_evt) begin
      case (state)
        IDLE: if (!data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d[bit_cnt] = data_s;
          if (bit_cnt == 3'd7) state_d = PARITY;
          else                 bit_cnt_d = bit_cnt + 1'b1;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          done    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (to_hit) begin
      state_d = IDLE;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              par <= 1'b0;
    else if (bit_evt && state == PARITY)  par <= data_s;
  end

  // Odd parity over data+parity bit, and the stop bit (sampled now) must be high.
  assign frame_ok = (^{shift, par}) && data_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.err <= 1'b0;
    else     bus.err <= done && !frame_ok;
  end
`else
  assign frame_ok = 1'b1;
  assign bus.err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.key   <= '0;
      bus.ready <= 1'b0;
    end else begin
      bus.ready <= done && frame_ok;
      if (done && frame_ok) bus.key <= {bus.key[7:0], shift};
    end
  end
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: frames, history, parity, timeout, glitches, mid-frame reset.
module tb_ps2_key_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_key_rx_if bus();

  ps2_key_rx #(.FILTER_LEN(8), .TIMEOUT(2000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [15:0] key_at_rdy [$];

  always @(negedge clk) begin
    if (bus.ready) begin
      rdy_cnt++;
      key_at_rdy.push_back(bus.key);
    end
    if (bus.err) err_cnt++;
    if (bus.ready && bus.err) both_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits bits of a frame; glitch_bit >= 0 adds a 3-cycle low
  // pulse on ps2_clk during that bit's high phase.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic stp,
                            input int nbits, input int glitch_bit);
    logic [10:0] fr;
    fr = {stp, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      if (i == glitch_bit) begin
        wait_clk(10);
        bus.ps2_clk = 1'b0;
        wait_clk(3);
        bus.ps2_clk = 1'b1;
        wait_clk(12);
      end else begin
        wait_clk(25);
      end
      bus.ps2_clk = 1'b0;
      wait_clk(50);
      bus.ps2_clk = 1'b1;
      wait_clk(25);
    end
    bus.ps2_data = 1'b1;
    wait_clk(30);
  endtask

  task automatic test_reset;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    wait_clk(3);
    n_vec++;
    if (bus.key !== 16'h0000) begin n_err++; $display("FAIL reset_key got=%h exp=0000", bus.key); end
    n_vec++;
    if (bus.ready !== 1'b0 || bus.err !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes got ready=%b err=%b exp 0/0", bus.ready, bus.err);
    end
    rst = 1'b0;
    wait_clk(20);
  endtask

  task automatic test_single;
    int r0;
    r0 = rdy_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    n_vec++;
    if (rdy_cnt - r0 !== 1) begin n_err++; $display("FAIL single_ready got=%0d exp=1", rdy_cnt - r0); end
    n_vec++;
    if (bus.key !== 16'h001C) begin n_err++; $display("FAIL single_key got=%h exp=001C", bus.key); end
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rdy_cnt;
    key_at_rdy.delete();
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    n_vec++;
    if (rdy_cnt - r0 !== 3) begin n_err++; $display("FAIL b2b_ready got=%0d exp=3", rdy_cnt - r0); end
    n_vec++;
    if (key_at_rdy.size() != 3 || key_at_rdy[1] !== 16'h1CF0) begin
      n_err++; $display("FAIL b2b_key2 got=%h exp=1CF0", key_at_rdy.size() > 1 ? key_at_rdy[1] : 16'hxxxx);
    end
    n_vec++;
    if (bus.key !== 16'hF01C) begin n_err++; $display("FAIL b2b_key3 got=%h exp=F01C", bus.key); end
  endtask

  task automatic test_parity;
    int r0, e0;
    logic [15:0] k0;
    r0 = rdy_cnt; e0 = err_cnt; k0 = bus.key;
    send_frame(8'h15, 1'b1, 1'b1, 11, -1);
`ifdef PS2_PARITY_CHECK_EN
    n_vec++;
    if (err_cnt - e0 !== 1 || rdy_cnt - r0 !== 0) begin
      n_err++; $display("FAIL parity_strobes got err=%0d rdy=%0d exp 1/0", err_cnt - e0, rdy_cnt - r0);
    end
    n_vec++;
    if (bus.key !== k0) begin n_err++; $display("FAIL parity_key got=%h exp=%h", bus.key, k0); end
`else
    n_vec++;
    if (err_cnt - e0 !== 0 || rdy_cnt - r0 !== 1) begin
      n_err++; $display("FAIL parity_strobes got err=%0d rdy=%0d exp 0/1", err_cnt - e0, rdy_cnt - r0);
    end
    n_vec++;
    if (bus.key !== {k0[7:0], 8'h15}) begin
      n_err++; $display("FAIL parity_key got=%h exp=%h", bus.key, {k0[7:0], 8'h15});
    end
`endif
  endtask

  task automatic test_timeout;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'hA7, 1'b1, 1'b1, 5, -1);
    wait_clk(2500);
    n_vec++;
    if (rdy_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
      n_err++; $display("FAIL timeout_strobes got rdy=%0d err=%0d exp 0/0", rdy_cnt - r0, err_cnt - e0);
    end
    send_frame(8'h1D, 1'b1, 1'b1, 11, -1);
    n_vec++;
    if (bus.key[7:0] !== 8'h1D || rdy_cnt - r0 !== 1) begin
      n_err++; $display("FAIL timeout_next got=%h rdy=%0d exp=1D rdy=1", bus.key[7:0], rdy_cnt - r0);
    end
  endtask

  task automatic test_glitch;
    int r0;
    r0 = rdy_cnt;
    bus.ps2_data = 1'b0;
    wait_clk(10);
    bus.ps2_clk = 1'b0;
    wait_clk(3);
    bus.ps2_clk = 1'b1;
    wait_clk(20);
    bus.ps2_data = 1'b1;
    wait_clk(40);
    n_vec++;
    if (rdy_cnt - r0 !== 0) begin n_err++; $display("FAIL glitch_idle got rdy=%0d exp=0", rdy_cnt - r0); end
    send_frame(8'h5A, 1'b1, 1'b1, 11, 4);
    n_vec++;
    if (bus.key[7:0] !== 8'h5A || rdy_cnt - r0 !== 1) begin
      n_err++; $display("FAIL glitch_frame got=%h rdy=%0d exp=5A rdy=1", bus.key[7:0], rdy_cnt - r0);
    end
  endtask

  task automatic test_mid_reset;
    int r0;
    send_frame(8'h33, 1'b1, 1'b1, 5, -1);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.key !== 16'h0000 || bus.ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_state got key=%h ready=%b exp 0000/0", bus.key, bus.ready);
    end
    wait_clk(3);
    rst = 1'b0;
    wait_clk(20);
    r0 = rdy_cnt;
    send_frame(8'h24, 1'b1, 1'b1, 11, -1);
    n_vec++;
    if (bus.key !== 16'h0024 || rdy_cnt - r0 !== 1) begin
      n_err++; $display("FAIL midrst_next got=%h rdy=%0d exp=0024 rdy=1", bus.key, rdy_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_timeout();
    test_glitch();
    test_mid_reset();
    n_vec++;
    if (both_cnt !== 0) begin n_err++; $display("FAIL ready_err_overlap got=%0d exp=0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
